// File: rtl/sm4_pkg.sv
// sm4_pkg: shared SM4 key-schedule definitions.
//   - FSM state type for the inverse key-expansion engine
//   - FK system parameter
//   - SM4 S-box table
//   - CK constant generator
package sm4_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StMk
    } state_e;

    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // CK_i byte j = ((4i + j) * 7) mod 256, byte 0 in the MSB position.
    function automatic logic [31:0] ck_gen(input logic [4:0] i);
        logic [31:0] ck;
        logic [7:0]  n;
        ck = '0;
        for (int j = 0; j < 4; j++) begin
            n = {1'b0, i, 2'b00} + 8'(j);
            ck[31 - 8 * j -: 8] = 8'(n * 8'd7);
        end
        return ck;
    endfunction

endpackage

// File: rtl/SM4_KEY_EXP_ONE_ROUND.sv
// SM4_KEY_EXP_ONE_ROUND: one round of the SM4 key expansion.
//   sm4_key_exp_in : {W0, W1, W2, W3}, W0 in [127:96]
//   sm4_key_cki    : round constant CK
//   sm4_rkey_out   : W0 ^ T'(W1 ^ W2 ^ W3 ^ CK)
// T' is the S-box layer followed by L'(B) = B ^ (B <<< 13) ^ (B <<< 23).
// Because the result is an XOR with W0, the same round serves the forward and
// inverse schedule; only the word ordering at the input differs.
module SM4_KEY_EXP_ONE_ROUND (
    input  logic [127:0] sm4_key_exp_in,
    input  logic [31:0]  sm4_key_cki,
    output logic [31:0]  sm4_rkey_out
);

    logic [31:0] x;
    logic [31:0] b;
    logic [31:0] l;

    assign x = sm4_key_exp_in[95:64] ^ sm4_key_exp_in[63:32] ^ sm4_key_exp_in[31:0]
             ^ sm4_key_cki;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        SM4_SBOX u_sbox (
            .din  (x[8 * g +: 8]),
            .dout (b[8 * g +: 8])
        );
    end

    assign l = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    assign sm4_rkey_out = sm4_key_exp_in[127:96] ^ l;

endmodule

// File: rtl/SM4_SBOX.sv
// SM4_SBOX: single 8-bit SM4 substitution box (pure combinational lookup).
//   din  : input byte
//   dout : substituted byte
module SM4_SBOX
    import sm4_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/sm4_key_exp_inv.sv
// sm4_key_exp_inv: iterative SM4 inverse key schedule.
// Loads {rk28, rk29, rk30, rk31} and emits rk31 down to rk0, one per
// rk_valid/rk_ready handshake, by running the key expansion backwards.
//   clk, rst          : clock, synchronous active-high reset
//   key_in_valid/ready: key load handshake (ready only while idle)
//   key_in            : {rk28, rk29, rk30, rk31}, rk28 in [127:96]
//   rk_valid/ready    : round-key output handshake
//   rk_out, rk_idx    : current round key and its index (31..0)
//   rk_last           : marks rk0
//   busy              : engine not idle
//   mk_out, mk_valid  : recovered master key, only when SM4_INV_MK_OUT_EN is defined
module sm4_key_exp_inv
    import sm4_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_in_valid,
    output logic         key_in_ready,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [31:0]  rk_out,
    output logic [4:0]   rk_idx,
    output logic         rk_last,
`ifdef SM4_INV_MK_OUT_EN
    output logic [127:0] mk_out,
    output logic         mk_valid,
`endif
    output logic         busy
);

    state_e       state_q, state_d;
    // S = {A, B, C, D}; A in [127:96], D in [31:0]
    logic [127:0] s_q, s_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [31:0]  new_k;
`ifdef SM4_INV_MK_OUT_EN
    logic [127:0] mk_out_q, mk_out_d;
`endif

    // Inverse step: K_i = K_{i+4} ^ T'(K_{i+1} ^ K_{i+2} ^ K_{i+3} ^ CK_i), with
    // S = {K_{i+1}, K_{i+2}, K_{i+3}, K_{i+4}} so the round input is {D, A, B, C}.
    SM4_KEY_EXP_ONE_ROUND u_round (
        .sm4_key_exp_in ({s_q[31:0], s_q[127:32]}),
        .sm4_key_cki    (ck_gen(cnt_q)),
        .sm4_rkey_out   (new_k)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
`ifdef SM4_INV_MK_OUT_EN
        mk_out_d = mk_out_q;
`endif
        case (state_q)
            StIdle: begin
                if (key_in_valid) begin
                    s_d     = key_in;
                    cnt_d   = 5'd31;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (rk_ready) begin
                    s_d   = {new_k, s_q[127:32]};
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
`ifdef SM4_INV_MK_OUT_EN
                        // After the rk0 beat S holds {K0..K3} = MK ^ FK.
                        mk_out_d = {new_k, s_q[127:32]} ^ FK;
                        state_d  = StMk;
`else
                        state_d  = StIdle;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            cnt_q   <= '0;
`ifdef SM4_INV_MK_OUT_EN
            mk_out_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
`ifdef SM4_INV_MK_OUT_EN
            mk_out_q <= mk_out_d;
`endif
        end
    end

    assign key_in_ready = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign rk_valid     = (state_q == StRun);
    assign rk_out       = s_q[31:0];
    assign rk_idx       = cnt_q;
    assign rk_last      = rk_valid && (cnt_q == 5'd0);
`ifdef SM4_INV_MK_OUT_EN
    assign mk_out       = mk_out_q;
    assign mk_valid     = (state_q == StMk);
`endif

endmodule

// File: tb/tb_sm4_key_exp_inv.sv
// tb_sm4_key_exp_inv: randomized scoreboard bench for sm4_key_exp_inv.
// A forward SM4 key-expansion model produces rk0..rk31 from a master key; the
// bench loads {rk28..rk31} and expects the DUT to return them in reverse.
module tb_sm4_key_exp_inv;

    localparam logic [127:0] STD_MK = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] TB_FK  = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    localparam logic [7:0] TB_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    typedef struct packed {
        logic [31:0]  rk;
        logic [4:0]   idx;
        logic [127:0] mk;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_in_valid = 1'b0;
    logic         key_in_ready;
    logic [127:0] key_in = '0;
    logic         rk_valid;
    logic         rk_ready = 1'b1;
    logic [31:0]  rk_out;
    logic [4:0]   rk_idx;
    logic         rk_last;
    logic         busy;
`ifdef SM4_INV_MK_OUT_EN
    logic [127:0] mk_out;
    logic         mk_valid;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic bp_mode = 1'b0;

    always #5 clk = ~clk;

    sm4_key_exp_inv dut (
        .clk          (clk),
        .rst          (rst),
        .key_in_valid (key_in_valid),
        .key_in_ready (key_in_ready),
        .key_in       (key_in),
        .rk_valid     (rk_valid),
        .rk_ready     (rk_ready),
        .rk_out       (rk_out),
        .rk_idx       (rk_idx),
        .rk_last      (rk_last),
`ifdef SM4_INV_MK_OUT_EN
        .mk_out       (mk_out),
        .mk_valid     (mk_valid),
`endif
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] t_prime(input logic [31:0] x);
        logic [31:0] b;
        b = {TB_SBOX[x[31:24]], TB_SBOX[x[23:16]], TB_SBOX[x[15:8]], TB_SBOX[x[7:0]]};
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    function automatic logic [31:0] ck_of(input int i);
        logic [31:0] c;
        for (int j = 0; j < 4; j++) c[31 - 8 * j -: 8] = 8'(((4 * i + j) * 7) % 256);
        return c;
    endfunction

    // Forward key expansion; queue rk31..rk0 and return {rk28..rk31}.
    task automatic build(input logic [127:0] mk, output logic [127:0] kin);
        logic [31:0]  k [36];
        logic [127:0] k0;
        exp_t         e;
        k0 = mk ^ TB_FK;
        for (int i = 0; i < 4; i++) k[i] = k0[127 - 32 * i -: 32];
        for (int i = 0; i < 32; i++) k[i + 4] = k[i] ^ t_prime(k[i + 1] ^ k[i + 2] ^ k[i + 3] ^ ck_of(i));
        kin = {k[32], k[33], k[34], k[35]};
        for (int i = 31; i >= 0; i--) begin
            e.rk  = k[i + 4];
            e.idx = 5'(i);
            e.mk  = mk;
            exp_q.push_back(e);
        end
    endtask

    // Called and returns at posedge+1.
    task automatic load(input logic [127:0] mk);
        logic [127:0] kin;
        int           n;
        build(mk, kin);
        key_in       = kin;
        key_in_valid = 1'b1;
        n = 0;
        while (!key_in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            chk("load_timeout", 128'(n), 128'(0));
            key_in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        key_in_valid = 1'b0;
        chk("first_rk_valid", 128'(rk_valid), 128'(1));
        chk("first_rk_idx", 128'(rk_idx), 128'(31));
        if (mk == STD_MK) chk("std_rk31", 128'(rk_out), 128'h9124A012);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) chk("drain_timeout", 128'(exp_q.size()), 128'(0));
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            rk_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: checks every valid cycle against the queue head, pops on accept.
    initial begin
        exp_t         e;
        logic         pend_ki = 1'b0;
        logic         pend_mk = 1'b0;
        logic [127:0] pend_mk_val = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_ki = 1'b0;
                pend_mk = 1'b0;
            end else begin
                if (pend_ki) begin
                    chk("ready_after_done", 128'(key_in_ready), 128'(1));
                    pend_ki = 1'b0;
                end
                if (pend_mk) begin
`ifdef SM4_INV_MK_OUT_EN
                    chk("mk_valid", 128'(mk_valid), 128'(1));
                    chk("mk_out", mk_out, pend_mk_val);
                    chk("ready_in_mk", 128'(key_in_ready), 128'(0));
`endif
                    pend_mk = 1'b0;
                    pend_ki = 1'b1;
                end
                if (rk_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rk", 128'(rk_out), 128'(0));
                    end else begin
                        e = exp_q[0];
                        chk("rk_out", 128'(rk_out), 128'(e.rk));
                        chk("rk_idx", 128'(rk_idx), 128'(e.idx));
                        chk("rk_last", 128'(rk_last), 128'(e.idx == 5'd0));
                        if (rk_ready) begin
                            void'(exp_q.pop_front());
                            if (e.idx == 5'd0) begin
                                if (e.mk == STD_MK) chk("std_rk0", 128'(rk_out), 128'hF12186F9);
`ifdef SM4_INV_MK_OUT_EN
                                pend_mk     = 1'b1;
                                pend_mk_val = e.mk;
`else
                                pend_ki     = 1'b1;
`endif
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_rk_valid", 128'(rk_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ready", 128'(key_in_ready), 128'(1));
        chk("rst_rk_out", 128'(rk_out), 128'(0));
        chk("rst_rk_idx", 128'(rk_idx), 128'(0));
        chk("rst_rk_last", 128'(rk_last), 128'(0));
`ifdef SM4_INV_MK_OUT_EN
        chk("rst_mk_valid", 128'(mk_valid), 128'(0));
        chk("rst_mk_out", mk_out, 128'(0));
`endif

        // Standard vector, consumer always ready.
        load(STD_MK);
        drain();

        // Random backpressure.
        bp_mode = 1'b1;
        load({$urandom, $urandom, $urandom, $urandom});
        load({$urandom, $urandom, $urandom, $urandom});
        drain();
        bp_mode = 1'b0;

        // Second key held valid during RUN; it is taken only once idle.
        load({$urandom, $urandom, $urandom, $urandom});
        load({$urandom, $urandom, $urandom, $urandom});
        drain();

        // Reset mid-stream at rk_idx 17.
        load({$urandom, $urandom, $urandom, $urandom});
        n = 0;
        while (rk_idx != 5'd17 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_idx17", 128'(rk_idx), 128'(17));
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        chk("midrst_rk_valid", 128'(rk_valid), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_ready", 128'(key_in_ready), 128'(1));
        chk("midrst_rk_last", 128'(rk_last), 128'(0));
        chk("midrst_rk_idx", 128'(rk_idx), 128'(0));
        rst = 1'b0;
        load({$urandom, $urandom, $urandom, $urandom});
        drain();

        // Back-to-back keys, then the standard vector once more under backpressure.
        load({$urandom, $urandom, $urandom, $urandom});
        load({$urandom, $urandom, $urandom, $urandom});
        drain();
        bp_mode = 1'b1;
        load(STD_MK);
        drain();
        bp_mode = 1'b0;

        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm4_key_exp_inv.md
# sm4_key_exp_inv

Iterative SM4 inverse key-schedule engine. It takes the last four round keys {rk28, rk29, rk30, rk31} and regenerates rk31 down to rk0 at one round key per handshake, by running the key expansion backwards. The decrypt datapath uses it to get the round keys in decryption order without a 32-entry round-key store. It runs one round per cycle on the existing single-round key-expansion datapath.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_in_valid` in 1: `key_in` is valid.
- `key_in_ready` out 1: engine can accept a key (high only in IDLE).
- `key_in` in 128: {rk28, rk29, rk30, rk31}, with rk28 in bits [127:96].
- `rk_valid` out 1: `rk_out` is valid.
- `rk_ready` in 1: consumer accepts `rk_out`.
- `rk_out` out 32: current round key.
- `rk_idx` out 5: index of `rk_out` (31 down to 0).
- `rk_last` out 1: high with `rk_valid` when `rk_idx` = 0.
- `busy` out 1: FSM is not in IDLE.
- `mk_out` out 128, `mk_valid` out 1: present only with `SM4_INV_MK_OUT_EN` (see Configuration).

## Operation
- State register S = {A, B, C, D}, 4×32 bits; 5-bit down-counter `cnt`.
- Recurrence, inverted from K_{i+4} = K_i ^ T'(K_{i+1}^K_{i+2}^K_{i+3}^CK_i):
  - K_i = K_{i+4} ^ T'(K_{i+1}^K_{i+2}^K_{i+3}^CK_i).
  - rk_i = K_{i+4}.
- Loaded S = {K32, K33, K34, K35}. `rk_out` = D. `rk_idx` = `cnt`.
- Each accepted output beat (`rk_valid` & `rk_ready`):
  - Compute newK = D ^ T'(A^B^C^CK_cnt).
  - S ← {newK, A, B, C}.
  - `cnt` ← `cnt` − 1.
- CK_i byte j = ((4i+j)·7) mod 256, with j = 0 as the MSB.
- FSM:
  - IDLE: `key_in_ready` = 1. On `key_in_valid`: S ← `key_in`, `cnt` ← 31, go to RUN.
  - RUN: `rk_valid` = 1.
    - Beat accepted with `cnt` > 0: stay in RUN.
    - Beat accepted with `cnt` = 0: go to MK if the macro is defined, otherwise IDLE.
    - `rk_ready` low: S, `cnt` and all outputs hold (no bubble, no skip).
  - MK (macro only): lasts exactly one cycle, `mk_valid` = 1, then go to IDLE.
- After the rk0 beat, S = {K0, K1, K2, K3} = MK ^ FK.
- FK = {A3B1BAC6, 56AA3350, 677D9197, B27022DC}.
- A `key_in_valid` pulse outside IDLE is ignored (ready is low). The source holds `key_in` until the handshake.

## Timing
- Reset values:
  - FSM = IDLE; S = 0; `cnt` = 0.
  - `rk_valid`, `rk_last`, `busy`, `mk_valid` = 0; `rk_out` = 0; `rk_idx` = 0.
  - `mk_out` = 0.
  - `key_in_ready` = 1 from the first cycle after `rst` deasserts.
- Key handshake in cycle t gives `rk_valid` = 1 with rk31 in cycle t+1 (1-cycle latency).
- Throughput: 1 rk per cycle while `rk_ready` is high. 32 output cycles.
- Next `key_in_ready`:
  - No macro: the cycle after the rk0 beat. Minimum 33 cycles per key.
  - With macro: one cycle later, after the MK cycle.
- `rk_out`, `rk_idx` and `rk_last` are driven from registers; there is no combinational path from `rk_ready` to them.
- `rst` asserted in any state, including mid-stream:
  - Next cycle is IDLE with reset values.
  - The partial sequence is discarded; no `rk_last` and no `mk_valid` are produced.
- The T' critical path (S-box plus linear transform) is one cycle; no pipelining.

## Configuration
- `SM4_INV_MK_OUT_EN` defined:
  - Adds the MK state and the ports `mk_out`/`mk_valid`.
  - In the MK cycle, `mk_out` is registered as S ^ FK (the recovered master key) and `mk_valid` pulses for exactly one cycle.
  - `mk_out` holds until the next completion or reset.
- `SM4_INV_MK_OUT_EN` undefined: the ports, the MK state and the FK XOR are absent; RUN goes directly to IDLE.

## Structure
- Shared package `sm4_pkg`:
  - FK constants.
  - CK generation function (or 32-entry CK table).
  - FSM state enum {IDLE, RUN, MK}.
- Sub-module: one instance of `SM4_KEY_EXP_ONE_ROUND`.
  - `sm4_key_exp_in` = {D, A, B, C}, `sm4_key_cki` = CK_cnt.
  - Its `sm4_rkey_out` is newK; XOR is symmetric, so no new round logic is needed.
  - It contains the four `SM4_SBOX` instances.

## Test plan
- Standard vector MK = 0123456789ABCDEFFEDCBA9876543210. Load `key_in` = golden {rk28..rk31}, `rk_ready` tied high:
  - beat 0: `rk_out` = 9124A012, `rk_idx` = 31.
  - beat 31: `rk_out` = F12186F9, `rk_idx` = 0, `rk_last` = 1.
  - All 32 values match the forward golden model in reverse order.
- Same vector with the macro defined → `mk_valid` pulses one cycle after the rk0 beat, with `mk_out` = 0123456789ABCDEFFEDCBA9876543210.
- Random `rk_ready` backpressure (~50%) → identical 32-word sequence, no duplicates or drops; `rk_out` stable while stalled.
- `key_in_valid` held high during RUN with a different key → ignored; the sequence is unchanged; the second key is accepted only in IDLE.
- `rst` pulsed at `rk_idx` = 17 → next cycle `rk_valid` = 0, `busy` = 0, `key_in_ready` = 1; a fresh load restarts at `rk_idx` = 31.
- Two back-to-back keys (random MK from the golden model) → key handshake-to-first-rk latency is 1 cycle for each; the second stream is fully correct.
